spi_segment_rx: RTL and testbench

SPI slave front-end that sits directly upstream of the 7-segment output stage in the TinyTapeout segment-controller top. It oversamples SPI pins in the system clock domain and decodes 16-bit command/data frames. It holds the segment pattern register that drives uo_out and a control register, and can read the pattern back on MISO. The top maps ui_in/uio pins onto its SPI ports and feeds seg_pattern to the display.

---
 rtl/spi_segment_rx_pkg.sv | 21 ++
 rtl/spi_input_sync.sv | 33 +++
 rtl/spi_segment_rx.sv | 220 ++++++++++++++++++++++
 tb/tb_spi_segment_rx.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/spi_segment_rx_pkg.sv
// Shared constants for the SPI segment receiver: command codes, FSM encoding
// and control-register bit positions.
package spi_segment_rx_pkg;

    // Command byte values (first byte of each 16-bit frame)
    localparam logic [7:0] CMD_WR_SEG  = 8'h01;
    localparam logic [7:0] CMD_WR_CTRL = 8'h02;
    localparam logic [7:0] CMD_RD_SEG  = 8'h81;

    // Frame FSM encoding
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CMD  = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    // ctrl_reg bit assignments; remaining bits are stored but reserved
    localparam int unsigned CTRL_BLANK = 0;

    localparam int unsigned FRAME_BITS = 16;

endpackage

// File: rtl/spi_input_sync.sv
// Multi-stage synchronizer for one asynchronous pin plus rise/fall detection
// on the synchronized value.
module spi_input_sync #(
    parameter int unsigned STAGES    = 2,
    parameter logic        RESET_VAL = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_pin,
    output logic o_sync,
    output logic o_rise,
    output logic o_fall
);

    logic [STAGES-1:0] r_sync;
    logic              r_prev;

    // Shift the pin through the synchronizer and keep the previous synced value
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync <= {STAGES{RESET_VAL}};
            r_prev <= RESET_VAL;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_pin};
            r_prev <= r_sync[STAGES-1];
        end
    end

    assign o_sync = r_sync[STAGES-1];
    assign o_rise = r_sync[STAGES-1] & ~r_prev;
    assign o_fall = ~r_sync[STAGES-1] & r_prev;

endmodule

// File: rtl/spi_segment_rx.sv
// SPI mode-0 slave that decodes 16-bit cmd/data frames into the segment
// pattern and control registers, with readback of the pattern on MISO.
module spi_segment_rx
    import spi_segment_rx_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic [7:0]  SEG_RESET   = 8'h00,
    parameter logic [7:0]  CTRL_RESET  = 8'h00
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       spi_sclk,
    input  logic       spi_cs_n,
    input  logic       spi_mosi,
    output logic       spi_miso,
    output logic       spi_miso_oe,
    output logic [7:0] seg_pattern,
    output logic [7:0] ctrl_reg,
    output logic       wr_strobe,
    output logic       frame_err
);

    logic w_sclk_sync_unused;
    logic w_sclk_rise;
    logic w_sclk_fall;
    logic w_cs_sync;
    logic w_cs_rise;
    logic w_cs_fall;
    logic w_mosi;
    logic w_mosi_rise_unused;
    logic w_mosi_fall_unused;

    spi_input_sync #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (1'b0)
    ) u_sync_sclk (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_pin   (spi_sclk),
        .o_sync  (w_sclk_sync_unused),
        .o_rise  (w_sclk_rise),
        .o_fall  (w_sclk_fall)
    );

    spi_input_sync #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (1'b1)
    ) u_sync_cs (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_pin   (spi_cs_n),
        .o_sync  (w_cs_sync),
        .o_rise  (w_cs_rise),
        .o_fall  (w_cs_fall)
    );

    spi_input_sync #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (1'b0)
    ) u_sync_mosi (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_pin   (spi_mosi),
        .o_sync  (w_mosi),
        .o_rise  (w_mosi_rise_unused),
        .o_fall  (w_mosi_fall_unused)
    );

    logic [1:0] r_state;
    logic [3:0] r_bit_cnt;
    logic [7:0] r_shift;
    logic [7:0] r_cmd;
    logic       r_ovf;
    logic [7:0] r_seg;
    logic [7:0] r_ctrl;
    logic       r_wr_strobe;
    logic       r_frame_err;
    logic [7:0] r_tx;
    logic       r_tx_active;

    logic [1:0] w_state_nxt;
    logic [3:0] w_bit_cnt_nxt;
    logic [7:0] w_shift_nxt;
    logic [7:0] w_cmd_nxt;
    logic       w_ovf_nxt;
    logic [7:0] w_seg_nxt;
    logic [7:0] w_ctrl_nxt;
    logic       w_wr_nxt;
    logic       w_err_nxt;
    logic [7:0] w_tx_nxt;
    logic       w_tx_active_nxt;
    logic [7:0] w_byte;

    // Frame decode: state, bit counter, shifter, register writes and tx shifter
    always_comb begin
        w_state_nxt     = r_state;
        w_bit_cnt_nxt   = r_bit_cnt;
        w_shift_nxt     = r_shift;
        w_cmd_nxt       = r_cmd;
        w_ovf_nxt       = r_ovf;
        w_seg_nxt       = r_seg;
        w_ctrl_nxt      = r_ctrl;
        w_wr_nxt        = 1'b0;
        w_err_nxt       = 1'b0;
        w_tx_nxt        = r_tx;
        w_tx_active_nxt = r_tx_active;
        w_byte          = {r_shift[6:0], w_mosi};

        if (!ena) begin
            // Disable silently drops any frame in progress
            w_state_nxt   = ST_IDLE;
            w_bit_cnt_nxt = 4'd0;
            w_ovf_nxt     = 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_cs_fall) begin
                        w_state_nxt   = ST_CMD;
                        w_bit_cnt_nxt = 4'd0;
                        w_ovf_nxt     = 1'b0;
                    end
                end
                ST_CMD: begin
                    // cs_n rise takes priority over a coincident sclk rise
                    if (w_cs_rise) begin
                        w_state_nxt = ST_IDLE;
                        w_err_nxt   = 1'b1;
                    end else if (w_sclk_rise) begin
                        w_shift_nxt   = w_byte;
                        w_bit_cnt_nxt = r_bit_cnt + 4'd1;
                        if (r_bit_cnt == 4'd7) begin
                            w_cmd_nxt   = w_byte;
                            w_state_nxt = ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    if (w_cs_rise) begin
                        w_state_nxt = ST_IDLE;
                        w_err_nxt   = 1'b1;
                    end else if (w_sclk_rise) begin
                        w_shift_nxt   = w_byte;
                        w_bit_cnt_nxt = r_bit_cnt + 4'd1;
                        if (r_bit_cnt == 4'(FRAME_BITS - 1)) begin
                            w_state_nxt = ST_DONE;
                            if (r_cmd == CMD_WR_SEG) begin
                                w_seg_nxt = w_byte;
                                w_wr_nxt  = 1'b1;
                            end else if (r_cmd == CMD_WR_CTRL) begin
                                w_ctrl_nxt = w_byte;
                                w_wr_nxt   = 1'b1;
                            end
                        end
                    end else if (w_sclk_fall) begin
                        // First fall of the data phase loads the readback byte
                        if (r_tx_active) begin
                            w_tx_nxt = {r_tx[6:0], 1'b0};
                        end else if (r_bit_cnt == 4'd8 && r_cmd == CMD_RD_SEG) begin
                            w_tx_nxt        = r_seg;
                            w_tx_active_nxt = 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    if (w_cs_rise) begin
                        w_state_nxt = ST_IDLE;
                        w_err_nxt   = r_ovf;
                        w_ovf_nxt   = 1'b0;
                    end else if (w_sclk_rise) begin
                        w_ovf_nxt = 1'b1;
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end

        // MISO only carries data while a read data phase is in progress
        if (w_state_nxt != ST_DATA) begin
            w_tx_active_nxt = 1'b0;
        end
    end

    // State and register update
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_bit_cnt   <= 4'd0;
            r_shift     <= 8'h00;
            r_cmd       <= 8'h00;
            r_ovf       <= 1'b0;
            r_seg       <= SEG_RESET;
            r_ctrl      <= CTRL_RESET;
            r_wr_strobe <= 1'b0;
            r_frame_err <= 1'b0;
            r_tx        <= 8'h00;
            r_tx_active <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_bit_cnt   <= w_bit_cnt_nxt;
            r_shift     <= w_shift_nxt;
            r_cmd       <= w_cmd_nxt;
            r_ovf       <= w_ovf_nxt;
            r_seg       <= w_seg_nxt;
            r_ctrl      <= w_ctrl_nxt;
            r_wr_strobe <= w_wr_nxt;
            r_frame_err <= w_err_nxt;
            r_tx        <= w_tx_nxt;
            r_tx_active <= w_tx_active_nxt;
        end
    end

    assign seg_pattern = r_seg;
    assign ctrl_reg    = r_ctrl;
    assign wr_strobe   = r_wr_strobe;
    assign frame_err   = r_frame_err;
    assign spi_miso    = r_tx_active & r_tx[7];
    assign spi_miso_oe = ena & ~w_cs_sync;

endmodule

// File: tb/tb_spi_segment_rx.sv
// Randomized bench for spi_segment_rx: frames are checked against a
// frame-level model of register contents, strobes and readback data.
module tb_spi_segment_rx;

    localparam logic [7:0] SEG_RST  = 8'h00;
    localparam logic [7:0] CTRL_RST = 8'h00;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic       spi_sclk;
    logic       spi_cs_n;
    logic       spi_mosi;
    logic       spi_miso;
    logic       spi_miso_oe;
    logic [7:0] seg_pattern;
    logic [7:0] ctrl_reg;
    logic       wr_strobe;
    logic       frame_err;

    int n_cmp;
    int n_bad;
    int wr_cnt;
    int err_cnt;
    int both_cnt;

    logic [7:0] m_seg;
    logic [7:0] m_ctrl;

    spi_segment_rx #(
        .SYNC_STAGES (2),
        .SEG_RESET   (SEG_RST),
        .CTRL_RESET  (CTRL_RST)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ena         (ena),
        .spi_sclk    (spi_sclk),
        .spi_cs_n    (spi_cs_n),
        .spi_mosi    (spi_mosi),
        .spi_miso    (spi_miso),
        .spi_miso_oe (spi_miso_oe),
        .seg_pattern (seg_pattern),
        .ctrl_reg    (ctrl_reg),
        .wr_strobe   (wr_strobe),
        .frame_err   (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse counters, sampled mid-cycle
    always @(negedge clk) begin
        if (wr_strobe) wr_cnt++;
        if (frame_err) err_cnt++;
        if (wr_strobe && frame_err) both_cnt++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ena_mode: 0 = enabled, 1 = disabled whole frame, 2 = disabled briefly mid-frame
    task automatic run_frame(input logic [7:0] cmd, input logic [7:0] data, input int nbits,
                             input int half, input int ena_mode);
        logic [15:0] word;
        logic [7:0]  rx;
        logic [7:0]  exp_rd;
        logic        oe_seen;
        int          exp_wr;
        int          exp_err;
        word    = {cmd, data};
        rx      = 8'h00;
        oe_seen = 1'b0;
        exp_rd  = m_seg;
        exp_wr  = 0;
        exp_err = 0;

        @(negedge clk);
        wr_cnt  = 0;
        err_cnt = 0;
        if (ena_mode == 1) ena = 1'b0;
        spi_cs_n = 1'b0;
        repeat (half) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            spi_mosi = (i < 16) ? word[15 - i] : 1'($urandom_range(0, 1));
            repeat (half) @(negedge clk);
            if (i >= 8 && i < 16) rx[15 - i] = spi_miso;
            if (i == 4) oe_seen = spi_miso_oe;
            if (ena_mode == 2 && i == 10) ena = 1'b0;
            if (ena_mode == 2 && i == 12) ena = 1'b1;
            spi_sclk = 1'b1;
            repeat (half) @(negedge clk);
            spi_sclk = 1'b0;
        end
        repeat (half) @(negedge clk);
        spi_cs_n = 1'b1;
        repeat (12) @(negedge clk);
        ena = 1'b1;

        // Frame-level model
        if (ena_mode == 0) begin
            if (nbits < 16) begin
                exp_err = 1;
            end else begin
                exp_err = (nbits > 16) ? 1 : 0;
                if (cmd == 8'h01) begin
                    m_seg  = data;
                    exp_wr = 1;
                end else if (cmd == 8'h02) begin
                    m_ctrl = data;
                    exp_wr = 1;
                end
            end
        end

        check_eq("wr_strobe_count", wr_cnt, exp_wr);
        check_eq("frame_err_count", err_cnt, exp_err);
        check_eq("seg_pattern", seg_pattern, m_seg);
        check_eq("ctrl_reg", ctrl_reg, m_ctrl);
        check_eq("miso_idle", spi_miso, 0);
        if (nbits > 4) check_eq("miso_oe_in_frame", oe_seen, (ena_mode == 1) ? 0 : 1);
        if (ena_mode == 0 && nbits >= 16)
            check_eq("miso_readback", rx, (cmd == 8'h81) ? exp_rd : 8'h00);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_seg"}, seg_pattern, SEG_RST);
        check_eq({tag, "_ctrl"}, ctrl_reg, CTRL_RST);
        check_eq({tag, "_miso"}, spi_miso, 0);
        check_eq({tag, "_oe"}, spi_miso_oe, 0);
        check_eq({tag, "_wr"}, wr_strobe, 0);
        check_eq({tag, "_err"}, frame_err, 0);
    endtask

    initial begin
        logic [7:0] cmd;
        int         nb;
        int         sel;
        int         mode;
        n_cmp    = 0;
        n_bad    = 0;
        wr_cnt   = 0;
        err_cnt  = 0;
        both_cnt = 0;
        m_seg    = SEG_RST;
        m_ctrl   = CTRL_RST;
        rst_n    = 1'b0;
        ena      = 1'b1;
        spi_sclk = 1'b0;
        spi_cs_n = 1'b1;
        spi_mosi = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Directed scenarios
        run_frame(8'h01, 8'h3F, 16, 4, 0);
        run_frame(8'h02, 8'h01, 16, 4, 0);
        run_frame(8'h01, 8'h5B, 16, 4, 0);
        run_frame(8'h81, 8'h00, 16, 4, 0);
        run_frame(8'h01, 8'hFF, 11, 4, 0);
        run_frame(8'h01, 8'h06, 19, 4, 0);
        run_frame(8'h55, 8'hAA, 16, 4, 0);
        run_frame(8'h01, 8'hFF, 16, 4, 1);
        run_frame(8'h02, 8'hC3, 16, 5, 2);

        // Reset asserted in the middle of a frame
        @(negedge clk);
        spi_cs_n = 1'b0;
        repeat (6) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            spi_mosi = 1'b1;
            spi_sclk = 1'b1;
            repeat (4) @(negedge clk);
            spi_sclk = 1'b0;
            repeat (4) @(negedge clk);
        end
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midframe_reset");
        m_seg  = SEG_RST;
        m_ctrl = CTRL_RST;
        spi_cs_n = 1'b1;
        spi_sclk = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Randomized frames
        for (int f = 0; f < 40; f++) begin
            sel = $urandom_range(0, 3);
            case (sel)
                0: cmd = 8'h01;
                1: cmd = 8'h02;
                2: cmd = 8'h81;
                default: cmd = 8'($urandom_range(0, 255));
            endcase
            sel = $urandom_range(0, 9);
            if (sel == 7) nb = $urandom_range(1, 15);
            else if (sel == 8) nb = $urandom_range(17, 19);
            else nb = 16;
            sel = $urandom_range(0, 9);
            mode = (sel == 8) ? 1 : (sel == 9) ? 2 : 0;
            run_frame(cmd, 8'($urandom_range(0, 255)), nb, $urandom_range(4, 7), mode);
        end

        check_eq("strobe_and_err_overlap", both_cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
